adxl362_spi_master: RTL and testbench
=====================================

Name: adxl362_spi_master

Overview:
Host-side SPI master that drives the ADXL362 SPI pins (SCLK, MOSI, nCS) and samples MISO. It is the stage directly upstream of the ADXL362 model's SPI slave.
It turns a single-cycle transaction request into a complete ADXL362 frame: register write (0x0A), register read (0x0B) or FIFO read (0x0D), with a multi-byte burst.
Write bytes are pulled from the user side; read bytes are returned one at a time with a valid pulse.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal values >= 2; SCLK = clk/(2*CLK_DIV)
LEN_W, 4, width of the burst length field

Ports:
clk  input  1  system clock; only clock in the block
rst  input  1  reset; asynchronous, active-low
start  input  1  request pulse; sampled only in IDLE
cmd  input  2  0=register write, 1=register read, 2=FIFO read, 3=reserved (start ignored)
address  input  8  register address; not sent for FIFO read
length  input  LEN_W  number of data bytes; 0 is treated as 1
wr_data  input  8  next write byte; sampled in the cycle wr_ack=1
wr_ack  output  1  one-cycle pulse: wr_data consumed for the next data byte
rd_data  output  8  last received data byte; held until the next byte
rd_valid  output  1  one-cycle pulse: rd_data updated
busy  output  1  transaction in progress
done  output  1  one-cycle pulse at transaction end
SCLK  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
MOSI  output  1  SPI data out, MSB first
nCS  output  1  chip select, active low
MISO  input  1  SPI data in

Behaviour:
- Reset values: nCS=1, SCLK=0, MOSI=0, busy=0, done=0, wr_ack=0, rd_valid=0, rd_data=0x00.
- Reset is asynchronous and takes effect immediately, including mid-frame: nCS=1, SCLK=0, FSM returns to IDLE, and no done pulse is issued.
- FSM states: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
- Frame bytes: N = 1 (command) + 1 (address, omitted for FIFO read) + L, where L = max(length,1). cmd, address and length are latched at start.
- Cycle 0: start is sampled in IDLE. busy=1 from cycle 1.
- SHIFT:
  - Cycle 1: nCS=0, MOSI=bit7 of the command byte.
  - Each bit: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MISO is sampled in the cycle SCLK rises.
  - MOSI changes in the cycle SCLK falls.
- HOLD: after the final falling edge, SCLK stays low for CLK_DIV cycles; then nCS=1.
- GAP: nCS stays high for CLK_DIV cycles (minimum deselect time).
- End of frame: done=1 and busy=0 in the same cycle, at cycle 1 + 16*CLK_DIV*N + 2*CLK_DIV. The FSM is in IDLE that cycle, so a new start is accepted on the next cycle.
- Write data:
  - wr_ack pulses in the cycle a write data byte is loaded into the shifter.
  - First data byte: on the falling edge that ends the address byte.
  - Subsequent data bytes: at each byte boundary.
  - There are exactly L wr_ack pulses per write. wr_ack is never asserted for read commands.
- Read data:
  - MOSI=0 during read data bytes.
  - rd_valid pulses one cycle after the 8th rising edge of each data byte, with rd_data holding that byte.
  - Bytes shifted in during the command and address bytes are discarded.
  - There are exactly L rd_valid pulses.
- start while busy=1, or with cmd=3: ignored, no state change.
- SCLK is never high while nCS=1.
- Bit counter is 3 bits and byte counter is LEN_W+1 bits; the byte counter must not wrap at length=2^LEN_W-1.

Decomposition:
- Shared include adxl362_spi_defines.vh, holding:
  - command constants ADXL362_CMD_WRITE=8'h0A, ADXL362_CMD_READ=8'h0B, ADXL362_CMD_FIFO=8'h0D;
  - cmd encodings;
  - FSM state encodings.
- Register address constants come from the existing ADXL362 register defines.
- One sub-module: adxl362_spi_shift8, an 8-bit MSB-first shift register with load, shift-on-fall, sample-on-rise and byte_done.

Test Plan:
- Write 0x13 to address 0x2C (CLK_DIV=4, length=1) -> MOSI bytes 0x0A,0x2C,0x13; one wr_ack; done at cycle 201; model FILTER_CTL odr=3.
- Read address 0x00, length=1, with the ADXL362 model attached -> rd_data=0xAD with one rd_valid; no wr_ack; done at cycle 201.
- Burst read address 0x00, length=3 -> rd_valid x3 with rd_data 0xAD, 0x1D, 0xF2; nCS stays low continuously for 5 bytes.
- FIFO read, length=2 -> MOSI first byte 0x0D with no address byte; 2 rd_valid; done at cycle 1+16*4*3+8=201.
- start pulsed while busy, and start with cmd=3 -> ignored; no extra SCLK edges, no done.
- rst asserted mid-address-byte -> nCS=1 and SCLK=0 in the same cycle, no done; a following write of 0x02 to 0x2D completes normally.

Source files
------------

// File: rtl/adxl362_spi_master_pkg.sv
// Shared constants for the ADXL362 SPI master: opcodes, user command encodings,
// FSM state encodings and the handful of ADXL362 register addresses in use.
package adxl362_spi_master_pkg;

   localparam logic [7:0] ADXL362_CMD_WRITE = 8'h0A;
   localparam logic [7:0] ADXL362_CMD_READ  = 8'h0B;
   localparam logic [7:0] ADXL362_CMD_FIFO  = 8'h0D;

   localparam logic [1:0] CMD_REG_WRITE = 2'd0;
   localparam logic [1:0] CMD_REG_READ  = 2'd1;
   localparam logic [1:0] CMD_FIFO_READ = 2'd2;
   localparam logic [1:0] CMD_RESERVED  = 2'd3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   localparam logic [7:0] ADXL362_REG_DEVID_AD   = 8'h00;
   localparam logic [7:0] ADXL362_REG_FILTER_CTL = 8'h2C;
   localparam logic [7:0] ADXL362_REG_POWER_CTL  = 8'h2D;

   function automatic logic [7:0] cmd_opcode(input logic [1:0] c);
      case (c)
         CMD_REG_READ:  cmd_opcode = ADXL362_CMD_READ;
         CMD_FIFO_READ: cmd_opcode = ADXL362_CMD_FIFO;
         default:       cmd_opcode = ADXL362_CMD_WRITE;
      endcase
   endfunction

endpackage

// File: rtl/adxl362_spi_shift8.sv
// 8-bit MSB-first SPI shifter: parallel load, shift out on SCLK fall,
// sample MISO on SCLK rise, with a 3-bit bit counter flagging the last bit.
module adxl362_spi_shift8
   import adxl362_spi_master_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] load_data_i,
   input  logic       shift_i,
   input  logic       sample_i,
   input  logic       miso_i,
   output logic       mosi_o,
   output logic [7:0] rx_byte_o,
   output logic       byte_done_o
);

   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic [2:0] bit_q, bit_d;

   always_comb begin
      tx_d  = tx_q;
      rx_d  = rx_q;
      bit_d = bit_q;
      if (load_i) begin
         tx_d  = load_data_i;
         bit_d = 3'd0;
      end else if (shift_i) begin
         tx_d  = {tx_q[6:0], 1'b0};
         bit_d = bit_q + 3'd1;
      end
      if (sample_i) begin
         rx_d = {rx_q[6:0], miso_i};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q  <= 8'h00;
         rx_q  <= 8'h00;
         bit_q <= 3'd0;
      end else begin
         tx_q  <= tx_d;
         rx_q  <= rx_d;
         bit_q <= bit_d;
      end
   end

   assign mosi_o      = tx_q[7];
   assign rx_byte_o   = rx_q;
   assign byte_done_o = (bit_q == 3'd7);

endmodule

// File: rtl/adxl362_spi_master.sv
// ADXL362 SPI master (mode 0): turns a one-cycle request into a complete
// command/address/burst frame, pulling write bytes and returning read bytes.
module adxl362_spi_master
   import adxl362_spi_master_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int LEN_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       cmd,
   input  logic [7:0]       address,
   input  logic [LEN_W-1:0] length,
   input  logic [7:0]       wr_data,
   output logic             wr_ack,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             busy,
   output logic             done,
   output logic             SCLK,
   output logic             MOSI,
   output logic             nCS,
   input  logic             MISO
);

   localparam int                 CNT_W    = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam int                 BYTE_W   = LEN_W + 1;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sclk_q, sclk_d;
   logic              ncs_q, ncs_d;
   logic              done_q, done_d;
   logic              rd_valid_q, rd_valid_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic [1:0]        cmd_q, cmd_d;
   logic [7:0]        addr_q, addr_d;
   logic [BYTE_W-1:0] byte_q, byte_d;
   logic [BYTE_W-1:0] last_q, last_d;

   logic              half_end, in_shift, rise, fall, byte_end, last_byte;
   logic              is_write, cur_is_data, next_is_data, accept;
   logic [BYTE_W-1:0] hdr_bytes, next_byte, len_ext;
   logic              sh_load, sh_shift, sh_byte_done, sh_mosi;
   logic [7:0]        sh_load_data, sh_rx;

   assign half_end     = (cnt_q == CNT_LAST);
   assign in_shift     = (state_q == ST_SHIFT);
   assign rise         = in_shift & ~sclk_q & half_end;
   assign fall         = in_shift & sclk_q & half_end;
   assign byte_end     = fall & sh_byte_done;
   assign last_byte    = (byte_q == last_q);
   assign is_write     = (cmd_q == CMD_REG_WRITE);
   assign hdr_bytes    = (cmd_q == CMD_FIFO_READ) ? BYTE_W'(1) : BYTE_W'(2);
   assign next_byte    = byte_q + BYTE_W'(1);
   assign cur_is_data  = (byte_q >= hdr_bytes);
   assign next_is_data = (next_byte >= hdr_bytes);
   assign accept       = (state_q == ST_IDLE) & start & (cmd != CMD_RESERVED);
   assign len_ext      = (length == '0) ? BYTE_W'(1) : {1'b0, length};

   // A write byte is consumed on the same edge it is loaded into the shifter.
   assign wr_ack = byte_end & ~last_byte & is_write & next_is_data;

   always_comb begin
      sh_load_data = 8'h00;
      if (accept) begin
         sh_load_data = cmd_opcode(cmd);
      end else if (!last_byte) begin
         if (!next_is_data)  sh_load_data = addr_q;
         else if (is_write)  sh_load_data = wr_data;
      end
   end

   assign sh_load  = accept | byte_end;
   assign sh_shift = fall & ~sh_byte_done;

   adxl362_spi_shift8 u_shift8 (
      .clk         (clk),
      .rst_n       (rst),
      .load_i      (sh_load),
      .load_data_i (sh_load_data),
      .shift_i     (sh_shift),
      .sample_i    (rise),
      .miso_i      (MISO),
      .mosi_o      (sh_mosi),
      .rx_byte_o   (sh_rx),
      .byte_done_o (sh_byte_done)
   );

   // The 8th bit of a byte is in the shifter during the first SCLK-high cycle.
   assign rd_valid_d = in_shift & sclk_q & (cnt_q == '0) & sh_byte_done
                       & cur_is_data & ~is_write;
   assign rd_data_d  = rd_valid_d ? sh_rx : rd_data_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sclk_d  = sclk_q;
      ncs_d   = ncs_q;
      done_d  = 1'b0;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      byte_d  = byte_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SHIFT;
               ncs_d   = 1'b0;
               sclk_d  = 1'b0;
               cnt_d   = '0;
               byte_d  = '0;
               cmd_d   = cmd;
               addr_d  = address;
               last_d  = (cmd == CMD_FIFO_READ) ? len_ext : len_ext + BYTE_W'(1);
            end
         end
         ST_SHIFT: begin
            cnt_d = half_end ? '0 : cnt_q + CNT_W'(1);
            if (half_end) sclk_d = ~sclk_q;
            if (byte_end) begin
               if (last_byte) state_d = ST_HOLD;
               else           byte_d  = next_byte;
            end
         end
         ST_HOLD: begin
            cnt_d = half_end ? '0 : cnt_q + CNT_W'(1);
            if (half_end) begin
               ncs_d   = 1'b1;
               state_d = ST_GAP;
            end
         end
         default: begin
            cnt_d = half_end ? '0 : cnt_q + CNT_W'(1);
            if (half_end) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sclk_q     <= 1'b0;
         ncs_q      <= 1'b1;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= 8'h00;
         cmd_q      <= CMD_REG_WRITE;
         addr_q     <= 8'h00;
         byte_q     <= '0;
         last_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sclk_q     <= sclk_d;
         ncs_q      <= ncs_d;
         done_q     <= done_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         byte_q     <= byte_d;
         last_q     <= last_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign SCLK     = sclk_q;
   assign nCS      = ncs_q;
   assign MOSI     = sh_mosi;

endmodule

// File: tb/tb_adxl362_spi_master.sv
// Bench for adxl362_spi_master with a behavioural ADXL362 SPI slave attached;
// expected bytes are queued at stimulus time and compared as the DUT delivers.
module tb_adxl362_spi_master;
   import adxl362_spi_master_pkg::*;

   localparam int CLK_DIV = 4;
   localparam int LEN_W   = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       cmd = 2'd0;
   logic [7:0]       address = 8'h00;
   logic [LEN_W-1:0] length = '0;
   logic [7:0]       wr_data = 8'h00;
   logic             wr_ack, rd_valid, busy, done, SCLK, MOSI, nCS;
   logic [7:0]       rd_data;
   logic             MISO = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] exp_rd[$];
   logic [7:0] exp_mosi[$];
   logic [7:0] got_rd[$];
   logic [7:0] wq[$];

   adxl362_spi_master #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .cmd(cmd), .address(address),
      .length(length), .wr_data(wr_data), .wr_ack(wr_ack), .rd_data(rd_data),
      .rd_valid(rd_valid), .busy(busy), .done(done), .SCLK(SCLK), .MOSI(MOSI),
      .nCS(nCS), .MISO(MISO)
   );

   always #5 clk = ~clk;

   // Behavioural ADXL362 slave, SPI mode 0.
   logic [7:0] regs [0:255] = '{0: 8'hAD, 1: 8'h1D, 2: 8'hF2, 3: 8'h02, 8: 8'h7E,
                                14: 8'h81, default: 8'h00};
   logic [7:0] fifo_mem [0:1] = '{8'h5A, 8'hC3};
   int         fifo_ptr = 0;
   logic [7:0] s_in = 8'h00, s_out = 8'h00, s_cmd = 8'h00, s_addr = 8'h00;
   int         s_bit = 0, s_byte = 0;
   logic       m_sclk_p = 1'b0, m_ncs_p = 1'b1;
   logic [7:0] mosi_got[$];

   always @(SCLK or nCS) begin
      if (m_ncs_p && !nCS) begin
         s_bit = 0; s_byte = 0; s_out = 8'h00; MISO = 1'b0;
      end else if (!nCS && !m_sclk_p && SCLK) begin
         s_in = {s_in[6:0], MOSI};
         s_bit++;
         if (s_bit == 8) begin
            s_bit = 0;
            mosi_got.push_back(s_in);
            if (s_byte == 0) s_cmd = s_in;
            else if (s_byte == 1 && s_cmd != ADXL362_CMD_FIFO) s_addr = s_in;
            else if (s_cmd == ADXL362_CMD_WRITE) begin regs[s_addr] = s_in; s_addr++; end
            if (s_cmd == ADXL362_CMD_READ && s_byte >= 1) begin
               s_out = regs[s_addr]; s_addr++;
            end else if (s_cmd == ADXL362_CMD_FIFO) begin
               s_out = fifo_mem[fifo_ptr % 2]; fifo_ptr++;
            end
            s_byte++;
         end
      end else if (!nCS && m_sclk_p && !SCLK) begin
         MISO  = s_out[7];
         s_out = {s_out[6:0], 1'b0};
      end
      m_sclk_p = SCLK;
      m_ncs_p  = nCS;
   end

   task automatic run_txn(input logic [1:0] c, input logic [7:0] a, input logic [LEN_W-1:0] l,
                          input int inj_cyc, output int done_cyc, output int n_ack,
                          output int n_rise, output int ncs_rise_cyc, output int bad,
                          output logic busy_ok, output int base);
      logic sclk_p, ncs_p;
      base = mosi_got.size();
      got_rd.delete();
      done_cyc = -1; n_ack = 0; n_rise = 0; ncs_rise_cyc = -1; bad = 0; busy_ok = 1'b1;
      sclk_p = 1'b0; ncs_p = 1'b0;
      @(negedge clk); start = 1'b1; cmd = c; address = a; length = l;
      @(negedge clk); start = 1'b0;
      for (int k = 1; k <= 3000; k++) begin
         if (k == 1 && (busy !== 1'b1 || nCS !== 1'b0)) busy_ok = 1'b0;
         if (k == inj_cyc) begin start = 1'b1; cmd = CMD_REG_READ; end
         if (k == inj_cyc + 1) start = 1'b0;
         if (wr_ack === 1'b1) begin
            n_ack++;
            wr_data = (wq.size() > 0) ? wq.pop_front() : 8'h00;
         end
         if (rd_valid === 1'b1) got_rd.push_back(rd_data);
         if (SCLK === 1'b1 && sclk_p == 1'b0) n_rise++;
         if (SCLK === 1'b1 && nCS === 1'b1) bad++;
         if (nCS === 1'b1 && ncs_p == 1'b0 && ncs_rise_cyc < 0) ncs_rise_cyc = k;
         sclk_p = SCLK; ncs_p = nCS;
         if (done === 1'b1) begin
            done_cyc = k;
            if (busy !== 1'b0) busy_ok = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      vectors++;
      if ({nCS, SCLK, MOSI, busy, done, wr_ack, rd_valid} !== 7'b1000000) begin
         $display("FAIL reset_ctrl: got %b want 1000000",
                  {nCS, SCLK, MOSI, busy, done, wr_ack, rd_valid});
         miscompares++;
      end
      vectors++;
      if (rd_data !== 8'h00) begin
         $display("FAIL reset_rd_data: got %h want 00", rd_data); miscompares++;
      end
   endtask

   task automatic test_write();
      int dc, na, nr, nc, bad, base; logic bok; logic [7:0] e, g;
      wq.push_back(8'h13);
      exp_mosi.push_back(ADXL362_CMD_WRITE); exp_mosi.push_back(ADXL362_REG_FILTER_CTL);
      exp_mosi.push_back(8'h13);
      run_txn(CMD_REG_WRITE, ADXL362_REG_FILTER_CTL, 4'd1, 0, dc, na, nr, nc, bad, bok, base);
      vectors++;
      if (dc !== 201) begin $display("FAIL write_done_cycle: got %0d want 201", dc); miscompares++; end
      vectors++;
      if (na !== 1) begin $display("FAIL write_wr_ack_count: got %0d want 1", na); miscompares++; end
      vectors++;
      if (got_rd.size() !== 0) begin
         $display("FAIL write_rd_valid_count: got %0d want 0", got_rd.size()); miscompares++;
      end
      vectors++;
      if (!bok || bad !== 0 || nr !== 24) begin
         $display("FAIL write_framing: busy_ok %0b sclk_while_ncs %0d rises %0d want 1 0 24", bok, bad, nr);
         miscompares++;
      end
      for (int i = 0; exp_mosi.size() > 0; i++) begin
         e = exp_mosi.pop_front();
         g = (base + i < mosi_got.size()) ? mosi_got[base + i] : 8'hxx;
         vectors++;
         if (g !== e) begin $display("FAIL write_mosi[%0d]: got %h want %h", i, g, e); miscompares++; end
      end
      vectors++;
      if (regs[ADXL362_REG_FILTER_CTL][2:0] !== 3'd3) begin
         $display("FAIL write_filter_odr: got %0d want 3", regs[ADXL362_REG_FILTER_CTL][2:0]);
         miscompares++;
      end
   endtask

   task automatic test_read();
      int dc, na, nr, nc, bad, base, nv; logic bok; logic [7:0] e, g;
      exp_rd.push_back(8'hAD);
      exp_mosi.push_back(ADXL362_CMD_READ); exp_mosi.push_back(ADXL362_REG_DEVID_AD);
      exp_mosi.push_back(8'h00);
      run_txn(CMD_REG_READ, ADXL362_REG_DEVID_AD, 4'd1, 0, dc, na, nr, nc, bad, bok, base);
      nv = got_rd.size();
      vectors++;
      if (dc !== 201 || !bok) begin $display("FAIL read_done_cycle: got %0d busy_ok %0b want 201 1", dc, bok); miscompares++; end
      vectors++;
      if (na !== 0 || nv !== 1) begin
         $display("FAIL read_pulse_counts: wr_ack %0d rd_valid %0d want 0 1", na, nv); miscompares++;
      end
      while (exp_rd.size() > 0) begin
         e = exp_rd.pop_front(); g = (got_rd.size() > 0) ? got_rd.pop_front() : 8'hxx;
         vectors++;
         if (g !== e) begin $display("FAIL read_rd_data: got %h want %h", g, e); miscompares++; end
      end
      for (int i = 0; exp_mosi.size() > 0; i++) begin
         e = exp_mosi.pop_front();
         g = (base + i < mosi_got.size()) ? mosi_got[base + i] : 8'hxx;
         vectors++;
         if (g !== e) begin $display("FAIL read_mosi[%0d]: got %h want %h", i, g, e); miscompares++; end
      end
   endtask

   task automatic test_burst_read();
      int dc, na, nr, nc, bad, base, nv; logic bok; logic [7:0] e, g;
      exp_rd.push_back(8'hAD); exp_rd.push_back(8'h1D); exp_rd.push_back(8'hF2);
      run_txn(CMD_REG_READ, 8'h00, 4'd3, 0, dc, na, nr, nc, bad, bok, base);
      nv = got_rd.size();
      vectors++;
      if (dc !== 329) begin $display("FAIL burst_done_cycle: got %0d want 329", dc); miscompares++; end
      vectors++;
      if (nc !== 325) begin $display("FAIL burst_ncs_release: got cycle %0d want 325", nc); miscompares++; end
      vectors++;
      if (nv !== 3 || nr !== 40) begin
         $display("FAIL burst_counts: rd_valid %0d rises %0d want 3 40", nv, nr); miscompares++;
      end
      for (int i = 0; exp_rd.size() > 0; i++) begin
         e = exp_rd.pop_front(); g = (got_rd.size() > 0) ? got_rd.pop_front() : 8'hxx;
         vectors++;
         if (g !== e) begin $display("FAIL burst_rd_data[%0d]: got %h want %h", i, g, e); miscompares++; end
      end
   endtask

   task automatic test_fifo_read();
      int dc, na, nr, nc, bad, base, nv; logic bok; logic [7:0] e, g;
      exp_rd.push_back(8'h5A); exp_rd.push_back(8'hC3);
      exp_mosi.push_back(ADXL362_CMD_FIFO); exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h00);
      run_txn(CMD_FIFO_READ, 8'h55, 4'd2, 0, dc, na, nr, nc, bad, bok, base);
      nv = got_rd.size();
      vectors++;
      if (dc !== 201) begin $display("FAIL fifo_done_cycle: got %0d want 201", dc); miscompares++; end
      vectors++;
      if (nv !== 2 || na !== 0) begin
         $display("FAIL fifo_counts: rd_valid %0d wr_ack %0d want 2 0", nv, na); miscompares++;
      end
      while (exp_rd.size() > 0) begin
         e = exp_rd.pop_front(); g = (got_rd.size() > 0) ? got_rd.pop_front() : 8'hxx;
         vectors++;
         if (g !== e) begin $display("FAIL fifo_rd_data: got %h want %h", g, e); miscompares++; end
      end
      for (int i = 0; exp_mosi.size() > 0; i++) begin
         e = exp_mosi.pop_front();
         g = (base + i < mosi_got.size()) ? mosi_got[base + i] : 8'hxx;
         vectors++;
         if (g !== e) begin $display("FAIL fifo_mosi[%0d]: got %h want %h", i, g, e); miscompares++; end
      end
   endtask

   task automatic test_length_bounds();
      int dc, na, nr, nc, bad, base, nv; logic bok; logic [7:0] e, g;
      exp_rd.push_back(8'h1D);
      run_txn(CMD_REG_READ, 8'h01, 4'd0, 0, dc, na, nr, nc, bad, bok, base);
      nv = got_rd.size();
      vectors++;
      if (dc !== 201 || nv !== 1) begin
         $display("FAIL len0_frame: done %0d rd_valid %0d want 201 1", dc, nv); miscompares++;
      end
      while (exp_rd.size() > 0) begin
         e = exp_rd.pop_front(); g = (got_rd.size() > 0) ? got_rd.pop_front() : 8'hxx;
         vectors++;
         if (g !== e) begin $display("FAIL len0_rd_data: got %h want %h", g, e); miscompares++; end
      end
      for (int i = 0; i < 15; i++) exp_rd.push_back(regs[i]);
      run_txn(CMD_REG_READ, 8'h00, 4'd15, 0, dc, na, nr, nc, bad, bok, base);
      nv = got_rd.size();
      vectors++;
      if (dc !== 1097 || nv !== 15 || nr !== 136) begin
         $display("FAIL len15_frame: done %0d rd_valid %0d rises %0d want 1097 15 136", dc, nv, nr);
         miscompares++;
      end
      for (int i = 0; exp_rd.size() > 0; i++) begin
         e = exp_rd.pop_front(); g = (got_rd.size() > 0) ? got_rd.pop_front() : 8'hxx;
         vectors++;
         if (g !== e) begin $display("FAIL len15_rd_data[%0d]: got %h want %h", i, g, e); miscompares++; end
      end
   endtask

   task automatic test_write_burst();
      int dc, na, nr, nc, bad, base; logic bok; logic [7:0] e, g;
      wq.push_back(8'hA5); wq.push_back(8'h3C);
      exp_mosi.push_back(ADXL362_CMD_WRITE); exp_mosi.push_back(8'h20);
      exp_mosi.push_back(8'hA5); exp_mosi.push_back(8'h3C);
      run_txn(CMD_REG_WRITE, 8'h20, 4'd2, 0, dc, na, nr, nc, bad, bok, base);
      vectors++;
      if (dc !== 265 || na !== 2) begin
         $display("FAIL wburst_frame: done %0d wr_ack %0d want 265 2", dc, na); miscompares++;
      end
      for (int i = 0; exp_mosi.size() > 0; i++) begin
         e = exp_mosi.pop_front();
         g = (base + i < mosi_got.size()) ? mosi_got[base + i] : 8'hxx;
         vectors++;
         if (g !== e) begin $display("FAIL wburst_mosi[%0d]: got %h want %h", i, g, e); miscompares++; end
      end
      vectors++;
      if ({regs[8'h20], regs[8'h21]} !== 16'hA53C) begin
         $display("FAIL wburst_regs: got %h%h want a53c", regs[8'h20], regs[8'h21]); miscompares++;
      end
   endtask

   task automatic test_ignored_start();
      int dc, na, nr, nc, bad, base, nv, activity; logic bok;
      run_txn(CMD_REG_READ, 8'h00, 4'd1, 50, dc, na, nr, nc, bad, bok, base);
      nv = got_rd.size();
      vectors++;
      if (dc !== 201 || nr !== 24 || nv !== 1) begin
         $display("FAIL busy_start: done %0d rises %0d rd_valid %0d want 201 24 1", dc, nr, nv);
         miscompares++;
      end
      activity = 0;
      @(negedge clk); start = 1'b1; cmd = CMD_RESERVED; address = 8'h2D; length = 4'd1;
      @(negedge clk); start = 1'b0;
      repeat (40) begin
         if (busy !== 1'b0 || nCS !== 1'b1 || SCLK !== 1'b0 || done !== 1'b0) activity++;
         @(negedge clk);
      end
      vectors++;
      if (activity !== 0) begin $display("FAIL reserved_cmd: active cycles %0d want 0", activity); miscompares++; end
   endtask

   task automatic test_reset_midframe();
      int dc, na, nr, nc, bad, base, n_done; logic bok, ncs_before; logic [7:0] e, g;
      @(negedge clk); start = 1'b1; cmd = CMD_REG_WRITE; address = ADXL362_REG_POWER_CTL; length = 4'd1;
      @(negedge clk); start = 1'b0;
      repeat (84) @(negedge clk);
      ncs_before = nCS;
      @(posedge clk); #1 rst = 1'b0; #1;
      vectors++;
      if (ncs_before !== 1'b0 || {nCS, SCLK, busy} !== 3'b100) begin
         $display("FAIL midframe_reset: ncs_before %b nCS/SCLK/busy %b want 0 100", ncs_before, {nCS, SCLK, busy});
         miscompares++;
      end
      n_done = 0;
      repeat (4) begin @(negedge clk); if (done === 1'b1) n_done++; end
      rst = 1'b1;
      repeat (4) begin @(negedge clk); if (done === 1'b1) n_done++; end
      vectors++;
      if (n_done !== 0) begin $display("FAIL midframe_no_done: got %0d want 0", n_done); miscompares++; end
      wq.push_back(8'h02);
      exp_mosi.push_back(ADXL362_CMD_WRITE); exp_mosi.push_back(ADXL362_REG_POWER_CTL);
      exp_mosi.push_back(8'h02);
      run_txn(CMD_REG_WRITE, ADXL362_REG_POWER_CTL, 4'd1, 0, dc, na, nr, nc, bad, bok, base);
      vectors++;
      if (dc !== 201 || na !== 1) begin
         $display("FAIL post_reset_write: done %0d wr_ack %0d want 201 1", dc, na); miscompares++;
      end
      for (int i = 0; exp_mosi.size() > 0; i++) begin
         e = exp_mosi.pop_front();
         g = (base + i < mosi_got.size()) ? mosi_got[base + i] : 8'hxx;
         vectors++;
         if (g !== e) begin $display("FAIL post_reset_mosi[%0d]: got %h want %h", i, g, e); miscompares++; end
      end
      vectors++;
      if (regs[ADXL362_REG_POWER_CTL] !== 8'h02) begin
         $display("FAIL post_reset_power_ctl: got %h want 02", regs[ADXL362_REG_POWER_CTL]); miscompares++;
      end
   endtask

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b1;
      @(negedge clk);
      test_write();
      test_read();
      test_burst_read();
      test_fifo_read();
      test_length_bounds();
      test_write_burst();
      test_ignored_start();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
